// File: rtl/lzc_normalizer_pkg.sv
// lzc_normalizer_pkg: shared mode encoding and count-width helper for the normalizer
// Contents:
//   LZC_MODE_ZERO / LZC_MODE_SIGN - in_mode encoding
//   lzc_cnt_w(bitwidth)           - width able to hold a count of 0..bitwidth
package lzc_normalizer_pkg;

    localparam logic LZC_MODE_ZERO = 1'b0;
    localparam logic LZC_MODE_SIGN = 1'b1;

    function automatic int lzc_cnt_w(input int bitwidth);
        return $clog2(bitwidth + 1);
    endfunction

endpackage

// File: rtl/lzc_count_core.sv
// lzc_count_core: combinational leading-zero counter
// Ports:
//   value - operand to scan from the MSB down
//   count - number of leading zero bits, BITWIDTH when value is all-zero
//   zero  - value is all-zero
module lzc_count_core #(
    parameter int BITWIDTH = 24,
    parameter int CNT_W    = 5
) (
    input  logic [BITWIDTH-1:0] value,
    output logic [CNT_W-1:0]    count,
    output logic                zero
);

    // Scanning upward lets the highest set bit overwrite every lower one.
    always_comb begin
        count = CNT_W'(BITWIDTH);
        for (int i = 0; i < BITWIDTH; i++)
            if (value[i]) count = CNT_W'(BITWIDTH - 1 - i);
    end

    assign zero = ~|value;

endmodule

// File: rtl/lzc_normalizer.sv
// lzc_normalizer: two-stage valid/ready mantissa normalizer with exponent adjust
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid/in_ready         - input handshake
//   in_mant, in_exp, in_mode  - operand, unsigned exponent, 0 = unsigned LZC, 1 = redundant sign bits
//   out_valid/out_ready       - output handshake
//   out_mant, out_exp         - normalized mantissa, adjusted exponent
//   out_count                 - raw count before exponent limiting
//   out_zero, out_underflow   - input was zero, shift was limited by the exponent
module lzc_normalizer
    import lzc_normalizer_pkg::*;
#(
    parameter int BITWIDTH  = 24,
    parameter int EXP_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BITWIDTH-1:0]               in_mant,
    input  logic [EXP_WIDTH-1:0]              in_exp,
    input  logic                              in_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BITWIDTH-1:0]               out_mant,
    output logic [EXP_WIDTH-1:0]              out_exp,
    output logic [lzc_cnt_w(BITWIDTH)-1:0]    out_count,
    output logic                              out_zero,
    output logic                              out_underflow
);

    localparam int CNT_W = lzc_cnt_w(BITWIDTH);

    logic [BITWIDTH-1:0]  core_in;
    logic [CNT_W-1:0]     core_count;
    logic                 core_zero;
    logic                 s1_valid, s1_mode, s1_zero, s1_adv;
    logic [BITWIDTH-1:0]  s1_mant;
    logic [EXP_WIDTH-1:0] s1_exp;
    logic [CNT_W-1:0]     s1_count;
    logic                 s2_valid;
    logic [CNT_W-1:0]     count;
    logic                 limited;
    logic [EXP_WIDTH-1:0] shift;

    // Sign mode: bits matching the MSB become zeros; the shift drops the MSB
    // itself so the count excludes it.
    assign core_in = (in_mode == LZC_MODE_SIGN) ? (in_mant ^ {BITWIDTH{in_mant[BITWIDTH-1]}}) << 1 : in_mant;

    lzc_count_core #(.BITWIDTH(BITWIDTH), .CNT_W(CNT_W)) u_core (
        .value (core_in),
        .count (core_count),
        .zero  (core_zero)
    );

    assign s1_adv   = ~s2_valid | out_ready;
    assign in_ready = ~s1_valid | s1_adv;

    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (in_ready)
            s1_valid <= in_valid;
    end

    // A zero core result in sign mode means all-zero or all-ones; only the
    // former is a zero operand.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_mant  <= in_mant;
            s1_exp   <= in_exp;
            s1_mode  <= in_mode;
            s1_count <= core_count;
            s1_zero  <= core_zero & ~in_mant[BITWIDTH-1];
        end
    end

    // Sign-mode counts top out one below the width (all-zero / all-ones case).
    assign count   = (s1_mode == LZC_MODE_SIGN && s1_count == CNT_W'(BITWIDTH)) ? CNT_W'(BITWIDTH - 1) : s1_count;
    assign limited = int'(count) > int'(s1_exp);
    assign shift   = limited ? s1_exp : EXP_WIDTH'(count);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            out_mant      <= '0;
            out_exp       <= '0;
            out_count     <= '0;
            out_zero      <= 1'b0;
            out_underflow <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_mant      <= s1_mant << shift;
                out_exp       <= s1_zero ? '0 : s1_exp - shift;
                out_count     <= count;
                out_zero      <= s1_zero;
                out_underflow <= limited & ~s1_zero;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_lzc_normalizer.sv
// tb_lzc_normalizer: directed and scoreboarded checks of lzc_normalizer (24-bit mantissa, 8-bit exponent)
module tb_lzc_normalizer;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic [4:0]  count;
        logic        zero;
        logic        uf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic [4:0]  out_count;
    logic        out_zero;
    logic        out_underflow;

    logic        rand_ready = 1'b0;
    logic        ready_fixed = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;
    int          popped = 0;
    res_t        q[$];

    lzc_normalizer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mant       (in_mant),
        .in_exp        (in_exp),
        .in_mode       (in_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mant      (out_mant),
        .out_exp       (out_exp),
        .out_count     (out_count),
        .out_zero      (out_zero),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Count leading bits directly from the MSB, then apply the exponent limit.
    function automatic res_t model(input logic [23:0] m, input logic [7:0] e, input logic md);
        res_t r;
        int   c = 0;
        int   sh;
        if (!md) begin
            while (c < 24 && m[23 - c] == 1'b0) c++;
        end else begin
            while (c < 24 && m[23 - c] == m[23]) c++;
            c = c - 1;
        end
        r.count = 5'(c);
        r.zero  = (m == 24'd0);
        if (r.zero) begin
            r.mant = '0;
            r.exp  = '0;
            r.uf   = 1'b0;
        end else begin
            sh     = (c < int'(e)) ? c : int'(e);
            r.mant = m << sh;
            r.exp  = 8'(int'(e) - sh);
            r.uf   = c > int'(e);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("sb_mant", 32'(out_mant), 32'(q[0].mant));
                    chk("sb_exp", 32'(out_exp), 32'(q[0].exp));
                    chk("sb_count", 32'(out_count), 32'(q[0].count));
                    chk("sb_zero", 32'(out_zero), 32'(q[0].zero));
                    chk("sb_underflow", 32'(out_underflow), 32'(q[0].uf));
                    if (out_ready) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_mant, in_exp, in_mode));
        end
    end

    task automatic directed(input logic md, input logic [23:0] m, input logic [7:0] e,
                            input logic [4:0] ec, input logic [23:0] em, input logic [7:0] ee,
                            input logic ez, input logic eu);
        in_mode  = md;
        in_mant  = m;
        in_exp   = e;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("dir_lat1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("dir_valid", 32'(out_valid), 32'd1);
        chk("dir_count", 32'(out_count), 32'(ec));
        chk("dir_mant", 32'(out_mant), 32'(em));
        chk("dir_exp", 32'(out_exp), 32'(ee));
        chk("dir_zero", 32'(out_zero), 32'(ez));
        chk("dir_underflow", 32'(out_underflow), 32'(eu));
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_mant"}, 32'(out_mant), 32'd0);
        chk({tag, "_out_exp"}, 32'(out_exp), 32'd0);
        chk({tag, "_out_count"}, 32'(out_count), 32'd0);
        chk({tag, "_out_zero"}, 32'(out_zero), 32'd0);
        chk({tag, "_out_underflow"}, 32'(out_underflow), 32'd0);
    endtask

    initial begin
        int p0;
        int t;
        int seen;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        directed(1'b0, 24'h000F00, 8'd20, 5'd12, 24'hF00000, 8'd14 - 8'd6, 1'b0, 1'b0);
        directed(1'b0, 24'h000001, 8'd5,  5'd23, 24'h000020, 8'd0,  1'b0, 1'b1);
        directed(1'b1, 24'hFFFF80, 8'd30, 5'd16, 24'h800000, 8'd14, 1'b0, 1'b0);
        directed(1'b1, 24'hFFFFFF, 8'd30, 5'd23, 24'h800000, 8'd7,  1'b0, 1'b0);
        directed(1'b0, 24'h000000, 8'd77, 5'd24, 24'h000000, 8'd0,  1'b1, 1'b0);
        directed(1'b1, 24'h000000, 8'd77, 5'd23, 24'h000000, 8'd0,  1'b1, 1'b0);
        directed(1'b1, 24'h000001, 8'd3,  5'd22, 24'h000008, 8'd0,  1'b0, 1'b1);
        directed(1'b0, 24'h800000, 8'd0,  5'd0,  24'h800000, 8'd0,  1'b0, 1'b0);

        // Random back-pressure, 100 back-to-back offers.
        rand_ready = 1'b1;
        p0 = popped;
        for (int i = 0; i < 100; i++) begin
            in_mant  = (i % 17 == 0) ? 24'd0 : 24'($urandom >> $urandom_range(0, 31));
            in_exp   = 8'($urandom_range(0, 40));
            in_mode  = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 50) begin
                t++;
                @(negedge clk);
            end
            if (t >= 50) chk("accept_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("rand_drain_empty", 32'(q.size()), 32'd0);
        chk("rand_popped", 32'(popped - p0), 32'd100);

        // Full throughput with out_ready held high.
        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        p0 = popped;
        for (int i = 0; i < 20; i++) begin
            in_mant  = 24'($urandom) >> i;
            in_exp   = 8'(i * 2);
            in_mode  = 1'(i % 2);
            in_valid = 1'b1;
            @(negedge clk);
            chk("tput_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("tput_popped", 32'(popped - p0), 32'd20);

        // Fill both stages under a stall, then reset.
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_mode  = 1'b0;
        in_mant  = 24'h001234;
        in_exp   = 8'd40;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_mant  = 24'h0000AB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("midrst");
        ready_fixed = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk("midrst_no_stale", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
